// File: rtl/dmem_resp.sv
// Data-memory responder: word-addressed RAM behind a stall-based handshake with
// the MEM stage. Each access stalls for 1+WAIT_CYCLES cycles, then one DONE cycle.
module dmem_resp #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        stallreq_o
);

  localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_idx;
  logic [3:0]            req_sel;
  logic [31:0]           req_wdata;
  logic [31:0]           ram [DEPTH];

  logic                  accept;
  logic                  fire;
  logic                  acc_we;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic [3:0]            acc_sel;
  logic [31:0]           acc_wdata;
  logic                  unused_addr;

  assign unused_addr = ^{mem_addr_i[31:ADDR_WIDTH+2], mem_addr_i[1:0]};

  // With zero wait cycles the access happens at the accepting edge, so it must
  // use the live request; otherwise it uses the copy latched on acceptance.
  always_comb begin
    accept = !rst && (state == IDLE) && mem_ce_i;
    fire   = 1'b0;
    if (!rst) begin
      if (state == IDLE && WAIT_CYCLES == 0) fire = mem_ce_i;
      else if (state == WAIT)                 fire = mem_ce_i && (cnt == '0);
    end
    if (state == IDLE) begin
      acc_we    = mem_we_i;
      acc_idx   = mem_addr_i[ADDR_WIDTH+1:2];
      acc_sel   = mem_sel_i;
      acc_wdata = mem_data_i;
    end else begin
      acc_we    = req_we;
      acc_idx   = req_idx;
      acc_sel   = req_sel;
      acc_wdata = req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      mem_data_o <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_we    <= mem_we_i;
        req_idx   <= mem_addr_i[ADDR_WIDTH+1:2];
        req_sel   <= mem_sel_i;
        req_wdata <= mem_data_i;
        cnt       <= CNT_INIT;
      end else if (state == WAIT && mem_ce_i && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      if (fire && !acc_we) mem_data_o <= ram[acc_idx];
    end
  end

  // RAM contents survive reset; only gated writes touch it.
  always_ff @(posedge clk) begin
    if (fire && acc_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (acc_sel[b]) ram[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_ce_i) state_nxt = (WAIT_CYCLES == 0) ? DONE : WAIT;
      WAIT:    if (!mem_ce_i) state_nxt = IDLE;
               else if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stallreq_o = 1'b0;
    if (!rst) begin
      case (state)
        IDLE, WAIT: stallreq_o = mem_ce_i;
        default:    stallreq_o = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: one instance with 2 wait cycles, one with none, sharing
// request fields but with separate chip enables, checked against a word-array model.
module tb_dmem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce0, ce2, we;
  logic [31:0] addr, wdata;
  logic [3:0]  sel;
  logic [31:0] data0, data2;
  logic        stall0, stall2;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [31:0] mdl [2][1024];
  logic [31:0] lr  [2];
  logic [31:0] rd;

  always #5 clk = ~clk;

  dmem_resp #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .mem_ce_i(ce0), .mem_we_i(we), .mem_addr_i(addr),
    .mem_sel_i(sel), .mem_data_i(wdata), .mem_data_o(data0), .stallreq_o(stall0)
  );

  dmem_resp #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .mem_ce_i(ce2), .mem_we_i(we), .mem_addr_i(addr),
    .mem_sel_i(sel), .mem_data_i(wdata), .mem_data_o(data2), .stallreq_o(stall2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stall_of(input int d);
    return (d == 0) ? {31'b0, stall0} : {31'b0, stall2};
  endfunction

  function automatic logic [31:0] data_of(input int d);
    return (d == 0) ? data0 : data2;
  endfunction

  task automatic set_ce(input int d, input logic v);
    if (d == 0) ce0 = v; else ce2 = v;
  endtask

  // Model: word index from byte address modulo depth; selected lanes replaced.
  task automatic model_access(input int d, input logic w, input logic [31:0] a,
                              input logic [3:0] s, input logic [31:0] dt);
    int unsigned idx;
    logic [31:0] mask;
    idx  = (a / 4) % 1024;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    if (w) mdl[d][idx] = (mdl[d][idx] & ~mask) | (dt & mask);
    else   lr[d] = mdl[d][idx];
  endtask

  // Full transaction: stall must hold for 1+wait cycles, then a DONE cycle with
  // stall low and the read data (or the held data after a write).
  task automatic access(input int d, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] dt,
                        input string tag, output logic [31:0] obs);
    int wc;
    wc = (d == 0) ? 0 : 2;
    @(negedge clk);
    we = w; addr = a; sel = s; wdata = dt;
    set_ce(d, 1'b1);
    for (int k = 0; k <= wc; k++) begin
      #1 check({tag, " stall"}, stall_of(d), 32'd1);
      @(negedge clk);
      if (k == 0) begin
        we = 1'($urandom); addr = $urandom; sel = 4'($urandom); wdata = $urandom;
      end
    end
    #1;
    model_access(d, w, a, s, dt);
    check({tag, " done_stall"}, stall_of(d), 32'd0);
    obs = data_of(d);
    check({tag, " data"}, obs, lr[d]);
    set_ce(d, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ce0 = 1'b0; ce2 = 1'b0; we = 1'b0; addr = '0; sel = '0; wdata = '0;
    lr[0] = '0; lr[1] = '0;

    repeat (2) @(negedge clk);
    #1;
    check("reset stall0", stall_of(0), 32'd0);
    check("reset stall2", stall_of(1), 32'd0);
    check("reset data0", data0, 32'h0);
    check("reset data2", data2, 32'h0);
    ce2 = 1'b1;
    #1 check("stall masked by rst", stall_of(1), 32'd0);
    @(negedge clk);
    ce2 = 1'b0; rst = 1'b0;
    #1 check("idle stall2", stall_of(1), 32'd0);

    // Known contents for the first 16 words of each instance.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++)
        access(d, 1'b1, i * 4, 4'hF, $urandom, "init", rd);

    access(1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, "wr 0x10", rd);
    access(1, 1'b0, 32'h10, 4'hF, 32'h0, "rd 0x10", rd);
    check("rd 0x10 value", rd, 32'hDEADBEEF);

    access(1, 1'b1, 32'h10, 4'b0100, 32'h55555555, "byte wr", rd);
    access(1, 1'b0, 32'h10, 4'hF, 32'h0, "byte rd", rd);
    check("byte rd value", rd, 32'hDE55BEEF);

    access(1, 1'b1, 32'h10, 4'b0000, 32'h01234567, "sel0 wr", rd);
    access(1, 1'b0, 32'h10, 4'hF, 32'h0, "sel0 rd", rd);
    check("sel0 rd value", rd, 32'hDE55BEEF);

    // Flush: drop chip enable in the second stall cycle of a read.
    @(negedge clk);
    we = 1'b0; addr = 32'h4; sel = 4'hF; ce2 = 1'b1;
    #1 check("flush stall1", stall_of(1), 32'd1);
    @(negedge clk);
    ce2 = 1'b0;
    #1 check("flush drop stall", stall_of(1), 32'd0);
    check("flush data hold", data2, lr[1]);
    @(negedge clk);
    #1 check("flush idle stall", stall_of(1), 32'd0);
    check("flush idle data", data2, lr[1]);
    access(1, 1'b0, 32'h8, 4'hF, 32'h0, "post flush", rd);

    // Reset in the middle of a write's wait.
    @(negedge clk);
    we = 1'b1; addr = 32'h20; sel = 4'hF; wdata = 32'h12345678; ce2 = 1'b1;
    #1 check("rstw stall", stall_of(1), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1 check("rstw stall in rst", stall_of(1), 32'd0);
    @(negedge clk);
    #1 check("rstw stall rst2", stall_of(1), 32'd0);
    rst = 1'b0; ce2 = 1'b0;
    lr[0] = '0; lr[1] = '0;
    @(negedge clk);
    #1 check("rstw stall after", stall_of(1), 32'd0);
    check("rstw data2", data2, 32'h0);
    check("rstw data0", data0, 32'h0);
    access(1, 1'b0, 32'h20, 4'hF, 32'h0, "rstw rd 0x20", rd);

    // Zero-wait back-to-back reads of 0x0 and 0x4.
    @(negedge clk);
    we = 1'b0; addr = 32'h0; sel = 4'hF; ce0 = 1'b1;
    #1 check("b2b stall A", stall_of(0), 32'd1);
    @(negedge clk);
    addr = 32'h4;
    model_access(0, 1'b0, 32'h0, 4'hF, 32'h0);
    #1 check("b2b done A stall", stall_of(0), 32'd0);
    check("b2b data A", data0, lr[0]);
    @(negedge clk);
    #1 check("b2b stall B", stall_of(0), 32'd1);
    @(negedge clk);
    ce0 = 1'b0;
    model_access(0, 1'b0, 32'h4, 4'hF, 32'h0);
    #1 check("b2b done B stall", stall_of(0), 32'd0);
    check("b2b data B", data0, lr[0]);

    // Address wrap.
    access(1, 1'b1, 32'h1000, 4'hF, 32'hA5A5A5A5, "wrap wr", rd);
    access(1, 1'b0, 32'h0, 4'hF, 32'h0, "wrap rd", rd);
    check("wrap value", rd, 32'hA5A5A5A5);

    // Random traffic on both instances over the initialised words.
    for (int n = 0; n < 80; n++) begin
      int          d;
      logic [31:0] a;
      d = int'($urandom_range(0, 1));
      a = $urandom;
      a[11:2] = 10'($urandom_range(0, 15));
      access(d, 1'($urandom), a, 4'($urandom), $urandom, "rand", rd);
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        #1 check("rand idle hold", data_of(d), lr[d]);
      end
      check("rand other hold", data_of(1 - d), lr[1 - d]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, word-address width; internal RAM depth is 2**ADDR_WIDTH 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2, number of wait cycles inserted per access; legal range 0..15.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 mem_ce_i  in  1  request valid (chip enable) from the MEM stage.
REQ-006 mem_we_i  in  1  1 = write, 0 = read.
REQ-007 mem_addr_i  in  32  byte address; bits [1:0] ignored; word index = mem_addr_i[ADDR_WIDTH+1:2].
REQ-008 mem_sel_i  in  4  byte-lane enables, big-endian: bit3 = data[31:24] (addr offset 0) ... bit0 = data[7:0] (offset 3).
REQ-009 mem_data_i  in  32  write data, already lane-replicated by the MEM stage.
REQ-010 mem_data_o  out  32  read data returned to the MEM stage (full word; the MEM stage extracts bytes and halfwords).
REQ-011 stallreq_o  out  1  pipeline stall request; 1 = hold the MEM stage and everything upstream.

Function
REQ-012 The FSM SHALL have three states: IDLE, WAIT, DONE.
REQ-013 IDLE with mem_ce_i=1: stallreq_o=1 (combinational, same cycle); addr, we, sel and wdata latched at the edge; next state WAIT with cnt=WAIT_CYCLES-1, or DONE if WAIT_CYCLES=0.
REQ-014 IDLE with mem_ce_i=0: stallreq_o=0; remain IDLE; no RAM access.
REQ-015 WAIT: stallreq_o=1; cnt decrements each cycle; at cnt=0 the access is performed at the edge and the next state is DONE.
REQ-016 Access execution: a write updates only the lanes whose latched sel bit is 1; a read loads the full addressed word into the mem_data_o register.
REQ-017 DONE: stallreq_o=0 so the pipeline advances at the closing edge; next state IDLE unconditionally; DONE SHALL NOT accept a new request.
REQ-018 Total stall per access is 1+WAIT_CYCLES cycles; mem_data_o is valid in the DONE cycle.
REQ-019 mem_data_o SHALL update only on read completion and hold its value otherwise, including through writes and idle cycles.
REQ-020 Inputs changing during WAIT SHALL be ignored; the latched request is used.
REQ-021 mem_ce_i=0 while in WAIT (flush) SHALL abort: no RAM write, mem_data_o unchanged, next state IDLE, stallreq_o=0 in that cycle.
REQ-022 A write with sel=4'b0000 SHALL complete normally and leave the RAM unchanged.
REQ-023 Addresses above the RAM depth SHALL wrap modulo 2**ADDR_WIDTH words; no error is signalled.
REQ-024 Back-to-back requests: the request following DONE is accepted in the next IDLE cycle, giving one non-stalled cycle (DONE) between accesses.

Reset
REQ-025 When rst=1 at an edge: state=IDLE, cnt=0, mem_data_o=32'h0, stallreq_o=0 in the following cycle.
REQ-026 Reset during WAIT SHALL cancel the pending access with no RAM write.
REQ-027 RAM contents SHALL NOT be cleared by reset.
REQ-028 While rst=1, stallreq_o SHALL be 0 regardless of mem_ce_i.

Verification
REQ-029 WAIT_CYCLES=2: write addr 0x10, sel 1111, data 0xDEADBEEF -> stallreq_o high for 3 cycles, then DONE; a later read of 0x10 returns 0xDEADBEEF in its DONE cycle.
REQ-030 Byte write: word 0x10 = 0xDEADBEEF; write sel 0100, data 0x55555555 -> read returns 0xDE55BEEF.
REQ-031 Flush: read request, mem_ce_i dropped in the 2nd stall cycle -> state IDLE next cycle, stallreq_o=0 in the drop cycle, mem_data_o keeps its prior value.
REQ-032 Reset mid-WAIT of a write 0x12345678 to 0x20 -> stallreq_o=0 after reset, mem_data_o=0, word 0x20 unchanged.
REQ-033 WAIT_CYCLES=0: back-to-back reads of 0x0 and 0x4 -> each stalls exactly 1 cycle, with one DONE cycle between them; data matches the RAM.
REQ-034 Wrap: ADDR_WIDTH=10, write 0xA5A5A5A5 to byte address 0x1000 -> a read of 0x0 returns 0xA5A5A5A5.
